ready_monitor: RTL
==================

READY_MONITOR -- requirements
Module: ready_monitor

Interface
REQ-001 Parameter MAX_LAT, default 1: number of sampled cycles mon_in may stay low after checking starts before a violation is flagged (range 0..255).
REQ-002 Parameter CNT_W, default 8: width of err_cnt (range 1..32).
REQ-003 Port clk  input  1  sole clock; all sampling on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high; acts as the disable condition, so no checking occurs while rst=1.
REQ-005 Port mon_in  input  1  observed signal, required high once checking is armed.
REQ-006 Port chk_en  input  1  check enable, sampled at posedge.
REQ-007 Port err_clr  input  1  synchronous clear of err_cnt and first_fail.
REQ-008 Port fail  output  1  registered one-cycle pulse per violating sample.
REQ-009 Port armed  output  1  high while state is ARMED.
REQ-010 Port first_fail  output  1  sticky flag, set by the first violation.
REQ-011 Port err_cnt  output  CNT_W  saturating violation count.

Function
REQ-012 FSM states: IDLE, WAIT, ARMED; internal lat_cnt is 8 bits wide.
REQ-013 IDLE: on a posedge with chk_en=1, go to WAIT with lat_cnt=0; no check is made on that edge.
REQ-014 WAIT, chk_en=1, mon_in=1: go to ARMED; no fail.
REQ-015 WAIT, chk_en=1, mon_in=0, lat_cnt<MAX_LAT: increment lat_cnt; stay in WAIT.
REQ-016 WAIT, chk_en=1, mon_in=0, lat_cnt==MAX_LAT: pulse fail on the next cycle; go to ARMED.
REQ-017 ARMED, chk_en=1: each posedge with mon_in=0 produces a fail pulse in the following cycle; consecutive low samples produce consecutive pulses.
REQ-018 Any state with chk_en=0 at a posedge: go to IDLE; no check on that edge; lat_cnt is cleared.
REQ-019 MAX_LAT=0: the first WAIT sample with mon_in=0 is a violation.
REQ-020 fail latency: exactly one clk after the violating sampling edge; fail is never high for a non-violating sample.
REQ-021 first_fail is set together with the first fail pulse and holds until err_clr or rst.
REQ-022 err_cnt increments by 1 per fail pulse and saturates at 2^CNT_W-1, with no wrap.
REQ-023 err_clr and a violation on the same edge: the clear applies first, so the result is err_cnt=1 and first_fail=1.
REQ-024 err_clr with no violation: err_cnt=0 and first_fail=0 on the next cycle; the FSM is unaffected.

Reset
REQ-025 rst=1 immediately forces: state=IDLE, lat_cnt=0, fail=0, armed=0, first_fail=0, err_cnt=0, independent of clk.
REQ-026 Reset asserted mid-WAIT or mid-ARMED aborts checking; a fail pulse in flight is cleared.
REQ-027 After rst deasserts, the first posedge with chk_en=1 enters WAIT per REQ-013.

Configuration
REQ-028 Macro READY_MON_ERR_CNT_EN defined: the err_cnt counter is implemented per REQ-022 to REQ-024.
REQ-029 Macro READY_MON_ERR_CNT_EN undefined: no counter is implemented, and err_cnt is constant 0; fail, armed and first_fail behave identically in both builds.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Good DUT, MAX_LAT=1: rst released, chk_en=1; mon_in=0 on the first WAIT sample, 1 from the second -> armed=1, fail never pulses, err_cnt=0.
- Late DUT, MAX_LAT=1: mon_in=0 for 3 samples, then 1 -> one fail pulse from the WAIT timeout, one from the first ARMED low sample; err_cnt=2, first_fail=1.
- Wrong-polarity stimulus: rst held 1 for 10 clocks with mon_in=0 -> fail=0, err_cnt=0 throughout.
- Reset mid-ARMED: mon_in dropped, then rst pulsed in the same cycle as the fail pulse -> fail cleared at once, err_cnt=0, state IDLE.
- Saturation, CNT_W=2: mon_in held 0 in ARMED for 6 samples -> err_cnt stops at 3; then err_clr with a violation on the same edge -> err_cnt=1.
- Build without READY_MON_ERR_CNT_EN: repeat the late-DUT case -> err_cnt=0; fail pulses and first_fail unchanged.

Source files
------------

// File: rtl/ready_monitor.sv
// ready_monitor: watches mon_in once checking is enabled. After chk_en
// rises, mon_in has MAX_LAT low samples of grace in WAIT. It must then be
// high on every sample while ARMED. Each violating sample gives a
// registered one-cycle fail pulse, sets the sticky first_fail flag and,
// when built with READY_MON_ERR_CNT_EN, increments a saturating err_cnt.
// Without READY_MON_ERR_CNT_EN, err_cnt is tied to zero.
module ready_monitor #(
    parameter int MAX_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_in,
    input  logic             chk_en,
    input  logic             err_clr,
    output logic             fail,
    output logic             armed,
    output logic             first_fail,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LAT_C = 8'(MAX_LAT);

    state_t     state_reg;
    logic [7:0] lat_cnt_reg;
    logic       fail_reg;
    logic       armed_reg;
    logic       first_fail_reg;
    logic       viol;

    // A violation is decided on the current sample. It becomes visible on
    // fail one cycle later through fail_reg.
    always_comb begin
        viol = 1'b0;
        if (chk_en) begin
            case (state_reg)
                WAIT:    viol = !mon_in && (lat_cnt_reg == MAX_LAT_C);
                ARMED:   viol = !mon_in;
                default: viol = 1'b0;
            endcase
        end
    end

    // Checking FSM with registered fail and armed outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 8'd0;
            fail_reg    <= 1'b0;
            armed_reg   <= 1'b0;
        end else if (!chk_en) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 8'd0;
            fail_reg    <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            fail_reg <= viol;
            case (state_reg)
                IDLE: begin
                    state_reg   <= WAIT;
                    lat_cnt_reg <= 8'd0;
                    armed_reg   <= 1'b0;
                end
                WAIT: begin
                    if (mon_in || (lat_cnt_reg >= MAX_LAT_C)) begin
                        state_reg <= ARMED;
                        armed_reg <= 1'b1;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 8'd1;
                    end
                end
                ARMED: begin
                    armed_reg <= 1'b1;
                end
                default: begin
                    state_reg   <= IDLE;
                    lat_cnt_reg <= 8'd0;
                    armed_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky first-failure flag. A clear on the same edge as a violation
    // leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_reg <= 1'b0;
        end else if (err_clr) begin
            first_fail_reg <= viol;
        end else if (viol) begin
            first_fail_reg <= 1'b1;
        end
    end

`ifdef READY_MON_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] err_cnt_reg;

    // Saturating violation counter. A clear takes effect before a violation
    // on the same edge, so the counter restarts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= viol ? CNT_ONE : '0;
        end else if (viol && (err_cnt_reg != CNT_MAX)) begin
            err_cnt_reg <= err_cnt_reg + CNT_ONE;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

    assign fail       = fail_reg;
    assign armed      = armed_reg;
    assign first_fail = first_fail_reg;

endmodule
